alu8_op_responder: RTL

//  Sequential, handshaked 8-bit unsigned ALU. It is the responder side of the ALU

---
 rtl/alu8_op_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu8_op_responder.sv
// Handshaked unsigned ALU responder: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide, one op in flight.
module alu8_op_responder #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            op,
  input  logic [DATA_W-1:0]     u_a,
  input  logic [DATA_W-1:0]     u_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*DATA_W-1:0]   u_result,
  output logic                  borrow,
  output logic                  err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_EQ  = 4'b0100;
  localparam logic [3:0] OP_GT  = 4'b0101;
  localparam logic [3:0] OP_LT  = 4'b0110;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mul_q, mul_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [DATA_W:0]       hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  borrow_q, borrow_d;
  logic                  err_q, err_d;

  logic [2*DATA_W-1:0]   sc_result;
  logic                  sc_borrow;
  logic                  sc_err;
  logic                  is_iter;
  logic [DATA_W:0]       sum_ab;
  logic [DATA_W:0]       mul_sum;
  logic [DATA_W:0]       rem_sh;
  logic [DATA_W:0]       div_diff;
  logic                  div_ge;

  assign is_iter  = (op == OP_MUL) || ((op == OP_DIV) && (u_b != '0));
  assign sum_ab   = {1'b0, u_a} + {1'b0, u_b};
  // hi_q never exceeds DATA_W bits between multiply steps, so the sum cannot overflow
  assign mul_sum  = hi_q + (lo_q[0] ? {1'b0, a_q} : '0);
  assign rem_sh   = {hi_q[DATA_W-1:0], lo_q[DATA_W-1]};
  assign div_ge   = rem_sh >= {1'b0, b_q};
  assign div_diff = rem_sh - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mul_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = is_iter ? CALC : DONE;
      CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sc_result = '0;
    sc_borrow = 1'b0;
    sc_err    = 1'b0;
    case (op)
      OP_AND: sc_result = {{DATA_W{1'b0}}, u_a & u_b};
      OP_OR:  sc_result = {{DATA_W{1'b0}}, u_a | u_b};
      OP_XOR: sc_result = {{DATA_W{1'b0}}, u_a ^ u_b};
      OP_NOT: sc_result = {{DATA_W{1'b0}}, ~u_a};
      OP_EQ:  sc_result = (u_a == u_b) ? '1 : '0;
      OP_GT:  sc_result = (u_a > u_b) ? '1 : '0;
      OP_LT:  sc_result = (u_a < u_b) ? '1 : '0;
      OP_ADD: sc_result = {{(DATA_W-1){1'b0}}, sum_ab};
      OP_SUB: begin
        sc_result = {{DATA_W{1'b0}}, u_a - u_b};
        sc_borrow = u_a < u_b;
      end
      // Only reached on the single-cycle path, i.e. divide by zero
      OP_DIV: begin
        sc_result = {u_a, {DATA_W{1'b1}}};
        sc_err    = 1'b1;
      end
      OP_MUL:  sc_result = '0;
      default: sc_err    = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mul_d = (op == OP_MUL);
          a_d   = u_a;
          b_d   = u_b;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = (op == OP_MUL) ? u_b : u_a;
          if (!is_iter) begin
            result_d = sc_result;
            borrow_d = sc_borrow;
            err_d    = sc_err;
          end
        end
      end
      CALC: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mul_q) begin
            {hi_d, lo_d} = {1'b0, mul_sum, lo_q[DATA_W-1:1]};
          end else begin
            hi_d = div_ge ? div_diff : rem_sh;
            lo_d = {lo_q[DATA_W-2:0], div_ge};
          end
        end else begin
          result_d = {hi_q[DATA_W-1:0], lo_q};
          borrow_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    u_result   = result_q;
    borrow     = borrow_q;
    err        = err_q;
  end

endmodule
